// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle datapath: synchronous
// store and clear, combinational load gated by MemRead.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] index;

    // Upper address bits are dropped so out-of-range addresses alias modulo depth.
    assign index = addr[DEPTH_LOG2-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    // Reset wins over a simultaneous write; the write is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            mem[index] <= write_data;
        end
    end

    // No write-through bypass: a same-cycle write becomes visible after the edge.
    always_comb begin
        read_data = '0;
        if (MemRead) begin
            read_data = mem[index];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a word-array model checked every negedge,
// plus literal expectations taken from the hand-worked scenarios.
`timescale 1ns/1ps
module tb_data_memory;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DL    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    int vectors     = 0;
    int miscompares = 0;

    // clock/reset block
    always #5 clk = ~clk;

    data_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH_LOG2(DL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .write_data(write_data),
        .read_data (read_data)
    );

    // Model: a plain word array indexed by address modulo depth.
    logic [DW-1:0] exp_mem [DEPTH];
    bit            model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
            model_valid = 1'b1;
        end else if (MemWrite) begin
            exp_mem[addr % DEPTH] = write_data;
        end
    end

    function automatic logic [DW-1:0] model_read();
        if (!MemRead) return '0;
        return exp_mem[addr % DEPTH];
    endfunction

    // Scoreboard compare on every falling edge once contents are defined.
    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if (read_data !== model_read()) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t addr=%h got=%h expected=%h",
                         $time, addr, read_data, model_read());
            end
        end
    end

    // driver tasks
    task automatic drive(input logic r, input logic mr, input logic mw,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        reset      = r;
        MemRead    = mr;
        MemWrite   = mw;
        addr       = a;
        write_data = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_lit(input string name, input logic [DW-1:0] want);
        #1;
        vectors++;
        if (read_data !== want) begin
            miscompares++;
            $display("FAIL %s addr=%h got=%h expected=%h", name, addr, read_data, want);
        end
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] wd);
        drive(1'b0, 1'b0, 1'b1, a, wd);
        step();
        MemWrite = 1'b0;
    endtask

    logic [AW-1:0] tbl_addr [8];
    logic [DW-1:0] tbl_data [8];

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        step();
        reset = 1'b0;

        // Reset clear sweep
        MemRead = 1'b1;
        addr = 32'd0;   check_lit("reset_clear_0", 32'h0);
        addr = 32'd1;   check_lit("reset_clear_1", 32'h0);
        addr = 32'd255; check_lit("reset_clear_255", 32'h0);

        // Idle: neither enable, write_data ignored
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h3);
        check_lit("idle_pre", 32'h0);
        step();
        check_lit("idle_post", 32'h0);
        MemRead = 1'b1;
        check_lit("idle_later_read", 32'h0);

        // Write then read, addr 0 and addr 1
        write_word(32'd0, 32'h3);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
        check_lit("wr_rd_addr0", 32'h3);
        write_word(32'd1, 32'h5);
        drive(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
        check_lit("wr_rd_addr1", 32'h5);
        addr = 32'd0;
        check_lit("addr0_kept", 32'h3);

        // Simultaneous read and write: old word until the edge
        write_word(32'd2, 32'hA);
        drive(1'b0, 1'b1, 1'b1, 32'd2, 32'hB);
        check_lit("rw_before_edge", 32'hA);
        step();
        check_lit("rw_after_edge", 32'hB);
        MemWrite = 1'b0;

        // Wrap modulo depth
        write_word(32'd256, 32'h7);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
        check_lit("wrap_read0", 32'h7);
        addr = 32'hFFFF_FF01;
        check_lit("wrap_high_alias1", 32'h5);
        addr = 32'd2;
        check_lit("word2_kept", 32'hB);

        // Reset priority over a simultaneous write
        write_word(32'd4, 32'h44);
        drive(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
        check_lit("pre_reset_addr4", 32'h44);
        drive(1'b1, 1'b0, 1'b1, 32'd4, 32'h9);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
        check_lit("reset_prio_addr4", 32'h0);
        addr = 32'd0;
        check_lit("reset_cleared_addr0", 32'h0);
        addr = 32'd2;
        check_lit("reset_cleared_addr2", 32'h0);

        // Directed table: write a spread of addresses, then read back
        for (int i = 0; i < 8; i++) begin
            tbl_addr[i] = 32'(i * 37 + 3);
            tbl_data[i] = 32'h1000_0000 + 32'(i * 32'h111);
        end
        for (int i = 0; i < 8; i++) write_word(tbl_addr[i], tbl_data[i]);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, tbl_addr[i], 32'h0);
            check_lit("table_readback", tbl_data[i]);
            step();
        end
        // A read with MemRead low must be zero even over a written word
        drive(1'b0, 1'b0, 1'b0, 32'd3, 32'h0);
        check_lit("read_gated_off", 32'h0);
        MemRead = 1'b1;
        check_lit("table_first_word", 32'h1000_0000);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
